control_sequencer: RTL and testbench

Microcoded control unit for the 8-bit computer. It sits directly upstream of the program counter and drives that block's `CE` (increment) and `J` (load from bus) strobes. It also drives every other register/bus strobe in the datapath. It steps a T-state counter through a fixed fetch followed by an opcode-specific execute sequence. Each instruction ends right after its last active micro-step, and the block stops permanently on HLT until reset.

---
 rtl/control_sequencer_pkg.sv | 49 ++++
 rtl/control_sequencer_if.sv | 37 +++
 rtl/control_sequencer_rom.sv | 98 +++++++++
 rtl/control_sequencer.sv | 75 +++++++
 tb/tb_control_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the 8-bit computer datapath: opcodes, T-states and
// the control word that the sequencer drives onto every register strobe.
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ro;
    logic ri;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic eo;
    logic su;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '0;

  typedef enum logic {
    SEQ_RUN    = 1'b0,
    SEQ_HALTED = 1'b1
  } seq_state_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath. Strobes are level
// signals valid for the whole cycle; the datapath samples them at the closing edge.
interface control_sequencer_if;
  logic [3:0] opcode;
  logic       flag_c;
  logic       flag_z;
  logic [2:0] step;
  logic       halted;
  logic       hlt;
  logic       mi;
  logic       ro;
  logic       ri;
  logic       io;
  logic       ii;
  logic       ai;
  logic       ao;
  logic       eo;
  logic       su;
  logic       bi;
  logic       oi;
  logic       ce;
  logic       co;
  logic       j;
  logic       fi;

  modport master (
    input  opcode, flag_c, flag_z,
    output step, halted, hlt, mi, ro, ri, io, ii, ai, ao, eo, su, bi, oi,
           ce, co, j, fi
  );

  modport slave (
    output opcode, flag_c, flag_z,
    input  step, halted, hlt, mi, ro, ri, io, ii, ai, ao, eo, su, bi, oi,
           ce, co, j, fi
  );
endinterface

// File: rtl/control_sequencer_rom.sv
// Combinational microcode: maps (step, opcode, flags) to a control word and a
// 'last' bit marking the final active step of the instruction.
module control_rom
  import sap_pkg::*;
(
  input  logic [2:0] step_i,
  input  logic [3:0] opcode_i,
  input  logic       flag_c_i,
  input  logic       flag_z_i,
  output ctrl_word_t ctrl_o,
  output logic       last_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    last_o = 1'b0;
    case (step_i)
      T0: begin
        ctrl_o.co = 1'b1;
        ctrl_o.mi = 1'b1;
      end
      T1: begin
        ctrl_o.ro = 1'b1;
        ctrl_o.ii = 1'b1;
        ctrl_o.ce = 1'b1;
        last_o    = (opcode_i inside {OP_NOP, [4'h9:4'hD]});
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o.io = 1'b1;
            ctrl_o.mi = 1'b1;
          end
          OP_LDI: begin
            ctrl_o.io = 1'b1;
            ctrl_o.ai = 1'b1;
            last_o    = 1'b1;
          end
          OP_JMP: begin
            ctrl_o.io = 1'b1;
            ctrl_o.j  = 1'b1;
            last_o    = 1'b1;
          end
          OP_JC: begin
            ctrl_o.io = 1'b1;
            ctrl_o.j  = flag_c_i;
            last_o    = 1'b1;
          end
          OP_JZ: begin
            ctrl_o.io = 1'b1;
            ctrl_o.j  = flag_z_i;
            last_o    = 1'b1;
          end
          OP_OUT: begin
            ctrl_o.ao = 1'b1;
            ctrl_o.oi = 1'b1;
            last_o    = 1'b1;
          end
          // HLT never ends: the top level freezes the step counter instead.
          OP_HLT:  ctrl_o.hlt = 1'b1;
          default: last_o     = 1'b1;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o.ro = 1'b1;
            ctrl_o.ai = 1'b1;
            last_o    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o.ro = 1'b1;
            ctrl_o.bi = 1'b1;
            ctrl_o.su = (opcode_i == OP_SUB);
          end
          OP_STA: begin
            ctrl_o.ao = 1'b1;
            ctrl_o.ri = 1'b1;
            last_o    = 1'b1;
          end
          default: last_o = 1'b1;
        endcase
      end
      T4: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ctrl_o.eo = 1'b1;
          ctrl_o.ai = 1'b1;
          ctrl_o.fi = 1'b1;
          ctrl_o.su = (opcode_i == OP_SUB);
        end
        last_o = 1'b1;
      end
      // Unreachable steps fall straight back to T0.
      default: last_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: T-state counter, sticky halt, and reset/halt gating
// of the control word produced by control_rom.
module control_sequencer
  import sap_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.master bus
);

  seq_state_t state_q, state_d;
  logic [2:0] step_q, step_d;
  ctrl_word_t rom_ctrl;
  ctrl_word_t ctrl;
  logic       rom_last;

  control_rom u_rom (
    .step_i   (step_q),
    .opcode_i (bus.opcode),
    .flag_c_i (bus.flag_c),
    .flag_z_i (bus.flag_z),
    .ctrl_o   (rom_ctrl),
    .last_o   (rom_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_RUN;
      step_q  <= T0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ctrl    = rom_ctrl;
    case (state_q)
      SEQ_RUN: begin
        if (rom_ctrl.hlt)  state_d = SEQ_HALTED;
        else if (rom_last) step_d  = T0;
        else               step_d  = step_q + 3'd1;
      end
      SEQ_HALTED: begin
        ctrl     = CTRL_IDLE;
        ctrl.hlt = 1'b1;
      end
      default: state_d = SEQ_RUN;
    endcase
    // Reset suppresses every strobe in the same cycle, not just the next one.
    if (rst) ctrl = CTRL_IDLE;
  end

  assign bus.step   = step_q;
  assign bus.halted = (state_q == SEQ_HALTED);
  assign bus.hlt    = ctrl.hlt;
  assign bus.mi     = ctrl.mi;
  assign bus.ro     = ctrl.ro;
  assign bus.ri     = ctrl.ri;
  assign bus.io     = ctrl.io;
  assign bus.ii     = ctrl.ii;
  assign bus.ai     = ctrl.ai;
  assign bus.ao     = ctrl.ao;
  assign bus.eo     = ctrl.eo;
  assign bus.su     = ctrl.su;
  assign bus.bi     = ctrl.bi;
  assign bus.oi     = ctrl.oi;
  assign bus.ce     = ctrl.ce;
  assign bus.co     = ctrl.co;
  assign bus.j      = ctrl.j;
  assign bus.fi     = ctrl.fi;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe/step sequences
// from a table-driven model, compared cycle by cycle at the falling edge.
module tb_control_sequencer;
  import sap_pkg::*;

  logic clk = 1'b0;
  logic rst;

  control_sequencer_if sif ();

  control_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] M_HLT = 16'h8000;
  localparam logic [15:0] M_MI  = 16'h4000;
  localparam logic [15:0] M_RO  = 16'h2000;
  localparam logic [15:0] M_RI  = 16'h1000;
  localparam logic [15:0] M_IO  = 16'h0800;
  localparam logic [15:0] M_II  = 16'h0400;
  localparam logic [15:0] M_AI  = 16'h0200;
  localparam logic [15:0] M_AO  = 16'h0100;
  localparam logic [15:0] M_EO  = 16'h0080;
  localparam logic [15:0] M_SU  = 16'h0040;
  localparam logic [15:0] M_BI  = 16'h0020;
  localparam logic [15:0] M_OI  = 16'h0010;
  localparam logic [15:0] M_CE  = 16'h0008;
  localparam logic [15:0] M_CO  = 16'h0004;
  localparam logic [15:0] M_J   = 16'h0002;
  localparam logic [15:0] M_FI  = 16'h0001;

  logic [15:0] exp_q[$];
  logic [2:0]  exp_step_q[$];
  logic [15:0] obs_q[$];
  logic [2:0]  obs_step_q[$];

  int checks = 0;
  int passed = 0;

  function automatic logic [15:0] sample();
    return {sif.hlt, sif.mi, sif.ro, sif.ri, sif.io, sif.ii, sif.ai, sif.ao,
            sif.eo, sif.su, sif.bi, sif.oi, sif.ce, sif.co, sif.j, sif.fi};
  endfunction

  function automatic void clear_queues();
    exp_q.delete();
    exp_step_q.delete();
    obs_q.delete();
    obs_step_q.delete();
  endfunction

  function automatic void expect_cycle(input logic [15:0] w, input logic [2:0] t);
    exp_q.push_back(w);
    exp_step_q.push_back(t);
  endfunction

  // Reference: one list of strobe sets per instruction, one entry per cycle.
  function automatic void model_instr(input logic [3:0] op, input bit fc, input bit fz);
    expect_cycle(M_CO | M_MI, 3'd0);
    expect_cycle(M_RO | M_II | M_CE, 3'd1);
    case (op)
      4'h1: begin
        expect_cycle(M_IO | M_MI, 3'd2);
        expect_cycle(M_RO | M_AI, 3'd3);
      end
      4'h2: begin
        expect_cycle(M_IO | M_MI, 3'd2);
        expect_cycle(M_RO | M_BI, 3'd3);
        expect_cycle(M_EO | M_AI | M_FI, 3'd4);
      end
      4'h3: begin
        expect_cycle(M_IO | M_MI, 3'd2);
        expect_cycle(M_RO | M_BI | M_SU, 3'd3);
        expect_cycle(M_EO | M_AI | M_FI | M_SU, 3'd4);
      end
      4'h4: begin
        expect_cycle(M_IO | M_MI, 3'd2);
        expect_cycle(M_AO | M_RI, 3'd3);
      end
      4'h5: expect_cycle(M_IO | M_AI, 3'd2);
      4'h6: expect_cycle(M_IO | M_J, 3'd2);
      4'h7: expect_cycle(M_IO | (fc ? M_J : 16'h0000), 3'd2);
      4'h8: expect_cycle(M_IO | (fz ? M_J : 16'h0000), 3'd2);
      4'hE: expect_cycle(M_AO | M_OI, 3'd2);
      4'hF: expect_cycle(M_HLT, 3'd2);
      default: ;
    endcase
  endfunction

  task automatic drive_cycles(input logic [3:0] op, input bit fc, input bit fz, input int n);
    sif.opcode = op;
    sif.flag_c = fc;
    sif.flag_z = fz;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_q.push_back(sample());
      obs_step_q.push_back(sif.step);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input bit fc, input bit fz);
    int n0;
    n0 = exp_q.size();
    model_instr(op, fc, fz);
    drive_cycles(op, fc, fz, exp_q.size() - n0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (sample() !== 16'h0000 || sif.step !== 3'd0)
        $display("FAIL reset_hold: strobes=%h step=%0d, expected strobes=0000 step=0", sample(), sif.step);
      else passed++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    clear_queues();
    model_instr(OP_ADD, 1'b0, 1'b0);
    while (exp_q.size() > 2) begin
      void'(exp_q.pop_back());
      void'(exp_step_q.pop_back());
    end
    drive_cycles(OP_ADD, 1'b0, 1'b0, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL add_prefix cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sample() !== 16'h0000 || sif.step !== ((i == 0) ? 3'd2 : 3'd0))
        $display("FAIL reset_mid_add cycle %0d: strobes=%h step=%0d, expected strobes=0000 step=%0d",
                 i, sample(), sif.step, (i == 0) ? 2 : 0);
      else passed++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    clear_queues();
    do_instr(OP_NOP, 1'b0, 1'b0);
    do_instr(OP_NOP, 1'b1, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL post_reset cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
  endtask

  task automatic test_ldi();
    clear_queues();
    do_instr(OP_LDI, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    do_instr(OP_NOP, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL ldi cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
  endtask

  task automatic test_sub();
    clear_queues();
    do_instr(OP_SUB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    do_instr(OP_ADD, 1'b0, 1'b1);
    do_instr(OP_LDI, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL sub_add cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
  endtask

  task automatic test_jc();
    clear_queues();
    do_instr(OP_JC, 1'b1, 1'($urandom_range(0, 1)));
    do_instr(OP_JC, 1'b0, 1'($urandom_range(0, 1)));
    do_instr(OP_JZ, 1'b0, 1'b1);
    do_instr(OP_JZ, 1'b1, 1'b0);
    do_instr(OP_NOP, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL cond_jump cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
  endtask

  task automatic test_undefined();
    clear_queues();
    do_instr(4'hB, 1'b1, 1'b1);
    do_instr(OP_JMP, 1'b0, 1'b0);
    do_instr(4'h9, 1'b0, 1'b0);
    do_instr(OP_STA, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL undefined cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    clear_queues();
    for (int k = 0; k < 40; k++)
      do_instr(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL random cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
  endtask

  task automatic test_rst_at_hlt_t2();
    clear_queues();
    model_instr(OP_HLT, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    void'(exp_step_q.pop_back());
    drive_cycles(OP_HLT, 1'b0, 1'b0, 2);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sample() !== 16'h0000)
      $display("FAIL rst_at_hlt_t2: strobes=%h, expected strobes=0000", sample());
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (sif.halted !== 1'b0 || sif.step !== 3'd0)
      $display("FAIL rst_at_hlt_t2_state: halted=%b step=%0d, expected halted=0 step=0", sif.halted, sif.step);
    else passed++;
    do_instr(OP_LDI, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL hlt_reset_resume cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
  endtask

  task automatic test_hlt();
    clear_queues();
    do_instr(OP_HLT, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL hlt_entry cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
    for (int i = 0; i < 20; i++) begin
      sif.opcode = 4'($urandom_range(0, 15));
      sif.flag_c = 1'($urandom_range(0, 1));
      sif.flag_z = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (sample() !== M_HLT || sif.step !== 3'd2 || sif.halted !== 1'b1)
        $display("FAIL halted cycle %0d: strobes=%h step=%0d halted=%b, expected strobes=%h step=2 halted=1",
                 i, sample(), sif.step, sif.halted, M_HLT);
      else passed++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sample() !== 16'h0000)
      $display("FAIL halted_reset: strobes=%h, expected strobes=0000", sample());
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_queues();
    do_instr(OP_OUT, 1'b0, 1'b0);
    do_instr(OP_LDA, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_step_q[i] !== exp_step_q[i])
        $display("FAIL halt_resume cycle %0d: strobes=%h step=%0d, expected strobes=%h step=%0d",
                 i, obs_q[i], obs_step_q[i], exp_q[i], exp_step_q[i]);
      else passed++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    sif.opcode = 4'h0;
    sif.flag_c = 1'b0;
    sif.flag_z = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ldi();
    test_sub();
    test_jc();
    test_undefined();
    test_random();
    test_rst_at_hlt_t2();
    test_hlt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
